// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store lane unit.
// Holds the access-size and exception encodings, the FSM state type and
// the parameter legality helpers used at elaboration.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    EXC_NONE = 2'b00,
    EXC_ADEL = 2'b01,
    EXC_ADES = 2'b10,
    EXC_BUS  = 2'b11
  } exc_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_e;

  function automatic bit data_w_ok(int w);
    return (w == 32) || (w == 64);
  endfunction

  function automatic bit timeout_ok(int t);
    return (t >= 1) && (t <= 255);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Handshake bundle between the M-stage, the lane unit and the data bus.
// slave  : the lane unit's view (takes requests, drives the bus, returns responses)
// master : the pipeline + memory view
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              flush;

  logic              bus_req;
  logic              bus_gnt;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;
  logic [NB-1:0]     bus_byteen;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic [1:0]        resp_exc;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, flush,
    input  bus_gnt, bus_rvalid, bus_rdata,
    output req_ready, bus_req, bus_addr, bus_we, bus_byteen, bus_wdata,
    output resp_valid, resp_data, resp_exc
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, flush,
    output bus_gnt, bus_rvalid, bus_rdata,
    input  req_ready, bus_req, bus_addr, bus_we, bus_byteen, bus_wdata,
    input  resp_valid, resp_data, resp_exc
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane steering for one access.
// size/off/uns : latched access size, byte offset within the bus word, zero-extend
// wdata        : right-justified store data -> wdata_sh shifted onto its lanes
// rdata        : raw bus word -> rdata_ext, extracted and extended to DATA_W
// byteen       : lanes touched by the access
module mem_access_unit_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB    = DATA_W / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [1:0]        size,
  input  logic [OFF_W-1:0]  off,
  input  logic              uns,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [NB-1:0]     byteen,
  output logic [DATA_W-1:0] wdata_sh,
  output logic [DATA_W-1:0] rdata_ext
);
  logic [NB-1:0]     be_base;
  logic [DATA_W-1:0] rsh;

  always_comb begin
    case (size)
      SZ_B:    be_base = NB'(8'h01);
      SZ_H:    be_base = NB'(8'h03);
      SZ_W:    be_base = NB'(8'h0F);
      default: be_base = NB'(8'hFF);
    endcase
  end

  assign byteen   = be_base << off;
  assign wdata_sh = wdata << {off, 3'b000};
  assign rsh      = rdata >> {off, 3'b000};

  always_comb begin
    rdata_ext = rsh;
    case (size)
      SZ_B: if (uns) rdata_ext = DATA_W'(rsh[7:0]);
            else     rdata_ext = DATA_W'($signed(rsh[7:0]));
      SZ_H: if (uns) rdata_ext = DATA_W'(rsh[15:0]);
            else     rdata_ext = DATA_W'($signed(rsh[15:0]));
      SZ_W: if (uns) rdata_ext = DATA_W'(rsh[31:0]);
            else     rdata_ext = DATA_W'($signed(rsh[31:0]));
      default: rdata_ext = rsh;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store lane unit between the M-stage and the data-memory bus.
// clk, reset : clock, synchronous active-high reset
// io (slave) : request from M-stage, bus request/grant/response, completion
// Accepts one access in IDLE, checks alignment, drives one bus request,
// waits for the response with a timeout, and returns a one-cycle response.
// A flush after grant parks in DRAIN so the outstanding response is absorbed.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave io
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  if (!data_w_ok(DATA_W)) begin : g_bad_data_w
    $error("mem_access_unit: DATA_W must be 32 or 64");
  end
  if (!timeout_ok(TIMEOUT)) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT must be 1..255");
  end

  state_e            state, state_nx;
  logic [7:0]        cnt;
  logic              lat_we, lat_uns;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  exc_e              resp_exc_q, resp_exc_d;
  logic              accept, misaligned, ld_resp, cnt_clr, timeout, bus_req;
  logic [OFF_W-1:0]  amask;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wd_sh, ld_ext;

  // Low address bits that must be zero for a naturally aligned access.
  assign amask      = OFF_W'((4'd1 << io.req_size) - 4'd1);
  assign misaligned = ((io.req_size == SZ_D) && (DATA_W == 32)) ||
                      ((io.req_addr[OFF_W-1:0] & amask) != '0);
  assign accept     = io.req_valid && (state == S_IDLE);
  // True in the TIMEOUT-th cycle spent in WAIT/DRAIN since the grant.
  assign timeout    = (cnt + 8'd1) == 8'(TIMEOUT);

  mem_access_unit_lane_align #(.DATA_W(DATA_W)) u_lane_align (
    .size      (lat_size),
    .off       (lat_addr[OFF_W-1:0]),
    .uns       (lat_uns),
    .wdata     (lat_wdata),
    .rdata     (io.bus_rdata),
    .byteen    (be),
    .wdata_sh  (wd_sh),
    .rdata_ext (ld_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      lat_we      <= 1'b0;
      lat_uns     <= 1'b0;
      lat_size    <= '0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      resp_data_q <= '0;
      resp_exc_q  <= EXC_NONE;
    end else begin
      state <= state_nx;
      if (cnt_clr) cnt <= '0;
      else if (state == S_WAIT || state == S_DRAIN) cnt <= cnt + 8'd1;
      if (accept) begin
        lat_we    <= io.req_we;
        lat_uns   <= io.req_unsigned;
        lat_size  <= io.req_size;
        lat_addr  <= io.req_addr;
        lat_wdata <= io.req_wdata;
      end
      if (ld_resp) begin
        resp_data_q <= resp_data_d;
        resp_exc_q  <= resp_exc_d;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_clr     = 1'b0;
    ld_resp     = 1'b0;
    resp_data_d = '0;
    resp_exc_d  = EXC_NONE;
    case (state)
      S_IDLE: if (accept) begin
        if (misaligned) begin
          state_nx = S_RESP;
          ld_resp  = 1'b1;
          if (io.req_we) resp_exc_d = EXC_ADES;
          else           resp_exc_d = EXC_ADEL;
        end else begin
          state_nx = S_REQ;
        end
      end
      S_REQ: begin
        if (io.bus_gnt) begin
          cnt_clr = 1'b1;
          if (io.flush) state_nx = S_DRAIN;
          else          state_nx = S_WAIT;
        end else if (io.flush) begin
          state_nx = S_IDLE;
        end
      end
      S_WAIT: begin
        // A flush that coincides with the response (or timeout) has nothing
        // left to drain, so it returns straight to IDLE.
        if (io.flush) begin
          if (io.bus_rvalid || timeout) state_nx = S_IDLE;
          else                          state_nx = S_DRAIN;
        end else if (io.bus_rvalid) begin
          state_nx = S_RESP;
          ld_resp  = 1'b1;
          if (!lat_we) resp_data_d = ld_ext;
        end else if (timeout) begin
          state_nx   = S_RESP;
          ld_resp    = 1'b1;
          resp_exc_d = EXC_BUS;
        end
      end
      S_DRAIN: if (io.bus_rvalid || timeout) state_nx = S_IDLE;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus_req       = (state == S_REQ);
  assign io.req_ready  = (state == S_IDLE);
  assign io.bus_req    = bus_req;
  assign io.bus_addr   = {lat_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign io.bus_we     = bus_req & lat_we;
  assign io.bus_byteen = bus_req ? be : '0;
  assign io.bus_wdata  = wd_sh;
  assign io.resp_valid = (state == S_RESP);
  assign io.resp_data  = resp_data_q;
  assign io.resp_exc   = resp_exc_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one 32-bit and one 64-bit instance
// share a single stimulus/observation path selected by 'sel'.
module tb_mem_access_unit;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        sel, req_valid, req_we, req_unsigned, flush, bus_gnt, bus_rvalid;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, bus_rdata;

  mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) io32 ();
  mem_access_unit_if #(.DATA_W(64), .ADDR_W(32)) io64 ();

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TIMEOUT)) u_dut32 (
    .clk(clk), .reset(reset), .io(io32));
  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TIMEOUT)) u_dut64 (
    .clk(clk), .reset(reset), .io(io64));

  assign io32.req_valid    = req_valid & ~sel;
  assign io32.req_we       = req_we;
  assign io32.req_size     = req_size;
  assign io32.req_unsigned = req_unsigned;
  assign io32.req_addr     = req_addr;
  assign io32.req_wdata    = req_wdata[31:0];
  assign io32.flush        = flush & ~sel;
  assign io32.bus_gnt      = bus_gnt & ~sel;
  assign io32.bus_rvalid   = bus_rvalid & ~sel;
  assign io32.bus_rdata    = bus_rdata[31:0];

  assign io64.req_valid    = req_valid & sel;
  assign io64.req_we       = req_we;
  assign io64.req_size     = req_size;
  assign io64.req_unsigned = req_unsigned;
  assign io64.req_addr     = req_addr;
  assign io64.req_wdata    = req_wdata;
  assign io64.flush        = flush & sel;
  assign io64.bus_gnt      = bus_gnt & sel;
  assign io64.bus_rvalid   = bus_rvalid & sel;
  assign io64.bus_rdata    = bus_rdata;

  logic        o_ready, o_bus_req, o_bus_we, o_resp_valid;
  logic [31:0] o_bus_addr;
  logic [7:0]  o_byteen;
  logic [63:0] o_wdata, o_resp_data;
  logic [1:0]  o_resp_exc;

  assign o_ready      = sel ? io64.req_ready  : io32.req_ready;
  assign o_bus_req    = sel ? io64.bus_req    : io32.bus_req;
  assign o_bus_we     = sel ? io64.bus_we     : io32.bus_we;
  assign o_bus_addr   = sel ? io64.bus_addr   : io32.bus_addr;
  assign o_byteen     = sel ? io64.bus_byteen : {4'b0, io32.bus_byteen};
  assign o_wdata      = sel ? io64.bus_wdata  : {32'b0, io32.bus_wdata};
  assign o_resp_valid = sel ? io64.resp_valid : io32.resp_valid;
  assign o_resp_data  = sel ? io64.resp_data  : {32'b0, io32.resp_data};
  assign o_resp_exc   = sel ? io64.resp_exc   : io32.resp_exc;

  typedef struct packed { logic [63:0] d; logic [1:0] e; } rsp_t;

  int          checks = 0, errors = 0;
  rsp_t        rq[$];
  bit          exp_bus = 1'b0;
  logic [31:0] e_addr;
  logic [7:0]  e_be;
  logic [63:0] e_wd;
  logic        e_we;
  logic [63:0] last_rdata;
  logic [1:0]  last_exc;
  logic [7:0]  last_be;
  int          last_nbreq;

  // ---------------- reference model (spec arithmetic) ----------------
  function automatic logic [7:0] m_be(int sz, int off);
    return 8'(((1 << (1 << sz)) - 1) << off);
  endfunction

  function automatic logic [63:0] m_wd(logic [63:0] wd, int off, int dw);
    logic [63:0] v;
    v = wd << (8 * off);
    if (dw == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  function automatic logic [63:0] m_ld(logic [63:0] rd, int sz, int off, bit uns, int dw);
    logic [63:0] v, mask;
    int nb;
    nb   = 8 << sz;
    mask = (nb == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nb) - 64'd1);
    v    = (rd >> (8 * off)) & mask;
    if (!uns && v[nb-1]) v = v | ~mask;
    if (dw == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  function automatic bit m_mis(int sz, logic [31:0] addr, int dw);
    return (sz == 3 && dw == 32) || ((addr % (1 << sz)) != 0);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle observer: bus fields while requesting, responses in order.
  task automatic compare_loop();
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (o_bus_req) begin
          if (!exp_bus) fail("bus_req_unexpected");
          else begin
            chk("bus_addr", 64'(o_bus_addr), 64'(e_addr));
            chk("bus_byteen", 64'(o_byteen), 64'(e_be));
            chk("bus_wdata", o_wdata, e_wd);
            chk("bus_we", 64'(o_bus_we), 64'(e_we));
          end
        end else begin
          chk("byteen_idle", 64'(o_byteen), 64'd0);
        end
        if (o_resp_valid) begin
          if (rq.size() == 0) fail("resp_unexpected");
          else begin
            r = rq.pop_front();
            chk("resp_data", o_resp_data, r.d);
            chk("resp_exc", 64'(o_resp_exc), 64'(r.e));
            last_rdata = o_resp_data;
            last_exc   = o_resp_exc;
          end
        end
      end
    end
  endtask

  // mode: 0 normal response, 1 flush in WAIT then late rvalid, 2 no rvalid
  task automatic access(input bit s, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [63:0] wd, input int gdly,
                        input int rdly, input logic [63:0] rd, input int mode);
    int   dw, off, n;
    bit   mis;
    rsp_t r;
    dw  = s ? 64 : 32;
    off = s ? int'(addr[2:0]) : int'(addr[1:0]);
    mis = m_mis(int'(sz), addr, dw);
    sel = s;
    e_addr = s ? {addr[31:3], 3'b000} : {addr[31:2], 2'b00};
    e_be   = m_be(int'(sz), off);
    e_wd   = m_wd(wd, off, dw);
    e_we   = we;
    if (mis)            begin r.d = 64'd0; r.e = we ? 2'b10 : 2'b01; end
    else if (mode == 2) begin r.d = 64'd0; r.e = 2'b11; end
    else                begin r.d = we ? 64'd0 : m_ld(rd, int'(sz), off, uns, dw); r.e = 2'b00; end
    if (mode != 1) rq.push_back(r);
    chk("req_ready", 64'(o_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    exp_bus = !mis;
    step();
    req_valid = 1'b0;
    last_be = o_byteen;
    last_nbreq = 0;
    if (mis) begin
      chk("mis_no_bus_req", 64'(o_bus_req), 64'd0);
      chk("mis_resp_next", 64'(o_resp_valid), 64'd1);
      step();
      return;
    end
    repeat (gdly) begin
      last_nbreq += int'(o_bus_req);
      step();
    end
    last_nbreq += int'(o_bus_req);
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    exp_bus = 1'b0;
    case (mode)
      0: begin
        repeat (rdly) step();
        bus_rvalid = 1'b1; bus_rdata = rd;
        step();
        bus_rvalid = 1'b0;
        chk("resp_after_rvalid", 64'(o_resp_valid), 64'd1);
        step();
      end
      1: begin
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("drain_not_ready", 64'(o_ready), 64'd0);
        bus_rvalid = 1'b1; bus_rdata = rd;
        step();
        bus_rvalid = 1'b0;
        chk("ready_after_drain", 64'(o_ready), 64'd1);
      end
      default: begin
        n = 0;
        while (!o_resp_valid && n < 40) begin
          step();
          n++;
        end
        chk("timeout_wait_cycles", 64'(n), 64'(TIMEOUT));
        step();
      end
    endcase
  endtask

  initial begin
    sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; flush = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    bus_rdata = '0; reset = 1'b1;
    fork
      compare_loop();
      begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_bus_req", 64'(o_bus_req), 64'd0);
    chk("rst_bus_we", 64'(o_bus_we), 64'd0);
    chk("rst_byteen", 64'(o_byteen), 64'd0);
    chk("rst_resp_valid", 64'(o_resp_valid), 64'd0);
    chk("rst_resp_data", o_resp_data, 64'd0);
    chk("rst_resp_exc", 64'(o_resp_exc), 64'd0);
    reset = 1'b0;
    step();

    // lb 0x1003, minimum latency (resp at T3 checked inside access)
    access(0, 0, 2'b00, 0, 32'h1003, 64'd0, 0, 0, 64'h80FF_1234, 0);
    chk("lb_byteen", 64'(last_be), 64'h8);
    chk("lb_data", last_rdata, 64'hFFFF_FF80);
    // lhu / lh 0x2002
    access(0, 0, 2'b01, 1, 32'h2002, 64'd0, 1, 2, 64'h9ABC_0000, 0);
    chk("lhu_byteen", 64'(last_be), 64'hC);
    chk("lhu_data", last_rdata, 64'h0000_9ABC);
    access(0, 0, 2'b01, 0, 32'h2002, 64'd0, 0, 1, 64'h9ABC_0000, 0);
    chk("lh_data", last_rdata, 64'hFFFF_9ABC);
    // misaligned store / load / dword on 32-bit bus
    access(0, 1, 2'b01, 0, 32'h0001, 64'h1234, 0, 0, 64'd0, 0);
    chk("sh_mis_exc", 64'(last_exc), 64'd2);
    access(0, 0, 2'b10, 0, 32'h0006, 64'd0, 0, 0, 64'd0, 0);
    chk("lw_mis_exc", 64'(last_exc), 64'd1);
    access(0, 1, 2'b11, 0, 32'h0008, 64'd5, 0, 0, 64'd0, 0);
    chk("sd32_exc", 64'(last_exc), 64'd2);
    // sb with grant delayed 3 cycles
    access(0, 1, 2'b00, 0, 32'h0102, 64'hAB, 3, 1, 64'hDEAD_BEEF, 0);
    chk("sb_breq_cycles", 64'(last_nbreq), 64'd4);
    chk("sb_byteen", 64'(last_be), 64'h4);
    chk("sb_resp_data", last_rdata, 64'd0);
    // timeout, flush-in-WAIT, then a normal access to show recovery
    access(0, 0, 2'b10, 0, 32'h0040, 64'd0, 0, 0, 64'd0, 2);
    chk("timeout_exc", 64'(last_exc), 64'd3);
    access(0, 0, 2'b10, 0, 32'h0044, 64'd0, 0, 0, 64'h1111_2222, 1);
    access(0, 0, 2'b10, 1, 32'h0048, 64'd0, 2, 0, 64'h8765_4321, 0);
    chk("lw_after_flush", last_rdata, 64'h8765_4321);

    // reset while requesting drops bus_req on the next edge
    sel = 1'b0;
    e_addr = 32'h0050; e_be = 8'hF; e_wd = 64'd0; e_we = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0050;
    exp_bus = 1'b1;
    step();
    req_valid = 1'b0;
    chk("pre_rst_bus_req", 64'(o_bus_req), 64'd1);
    reset = 1'b1;
    step();
    chk("midrst_bus_req", 64'(o_bus_req), 64'd0);
    chk("midrst_ready", 64'(o_ready), 64'd1);
    reset = 1'b0;
    exp_bus = 1'b0;
    step();

    // 64-bit instance
    access(1, 0, 2'b11, 0, 32'h0018, 64'd0, 0, 0, 64'h8000_0000_0000_0001, 0);
    chk("ld_byteen", 64'(last_be), 64'hFF);
    chk("ld_data", last_rdata, 64'h8000_0000_0000_0001);
    access(1, 0, 2'b11, 0, 32'h001C, 64'd0, 0, 0, 64'd0, 0);
    chk("ld_mis_exc", 64'(last_exc), 64'd1);
    access(1, 0, 2'b10, 0, 32'h0024, 64'd0, 1, 1, 64'h8765_4321_0000_0000, 0);
    chk("lw64_byteen", 64'(last_be), 64'hF0);
    chk("lw64_data", last_rdata, 64'hFFFF_FFFF_8765_4321);
    access(1, 1, 2'b01, 0, 32'h0016, 64'hBEEF, 1, 0, 64'd0, 0);
    access(1, 1, 2'b11, 0, 32'h0010, 64'h1122_3344_5566_7788, 2, 0, 64'd0, 0);

    step();
    chk("resp_queue_empty", 64'(rq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
